// File: rtl/dac_if_pkg.sv
// Shared definitions for the serial DAC interface.
// Covers the FSM encoding, the command-word field positions and the frame-length arithmetic.
package dac_if_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } dac_state_t;

  localparam int DAC_WORD_W   = 16;
  localparam int DAC_CH_BIT   = 15;
  localparam int DAC_CODE_MSB = 11;
  localparam int DAC_CODE_LSB = 4;

  // Total clk cycles from the first cycle of CS_N low to the earliest start of the next frame.
  function automatic int frame_len(input int cs_setup, input int clk_div, input int word_w,
                                   input int cs_hold, input int cs_idle);
    return cs_setup + 2 * clk_div * word_w + cs_hold + cs_idle;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dac_sclk_tick.sv
// Half-period timer for SCLK: o_tick marks the last clk cycle of each CLK_DIV-long half period.
module dac_sclk_tick
  import dac_if_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;

  assign o_tick = i_en && (r_div == DIV_W'(CLK_DIV - 1));

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_div <= '0;
    else if (!i_en || o_tick) r_div <= '0;
    else                     r_div <= r_div + 1'b1;
  end

endmodule

// File: rtl/dac_serial_if.sv
// Shifts 16-bit DAC command words MSB-first over a CS_N/SCLK/DIN link.
// Holds one pending word so a strobe that arrives mid-frame is not lost.
module dac_serial_if
  import dac_if_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int WORD_W   = DAC_WORD_W,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] dac_value,
  input  logic              dac_set,
  output logic              dac_cs_n,
  output logic              dac_sclk,
  output logic              dac_din,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = $clog2(max3(CS_SETUP, CS_HOLD, CS_IDLE) + 1);

  dac_state_t        r_state;
  dac_state_t        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_pend;
  logic              r_pend_v;
  logic              r_set_d;
  logic              r_phase;
  logic [4:0]        r_bit_cnt;
  logic              r_overrun;

  logic              w_req;
  logic              w_tick;
  logic              w_last_bit;
  logic              w_gap_end;
  logic              w_load;
  logic [WORD_W-1:0] w_load_word;
  logic              w_in_frame;

  assign w_req       = dac_set && !r_set_d;
  assign w_last_bit  = (r_bit_cnt == 5'(WORD_W - 1));
  assign w_gap_end   = (r_state == ST_GAP) && (r_cnt == CNT_W'(CS_IDLE - 1));
  // A strobe landing on the GAP exit cycle starts the next frame directly instead of being buffered.
  assign w_load      = ((r_state == ST_IDLE) && w_req) ||
                       (w_gap_end && (r_pend_v || w_req));
  assign w_load_word = w_req ? dac_value : r_pend;

  dac_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_en   (r_state == ST_SHIFT),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: default assignment first so no path through the case leaves w_next unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_req) w_next = ST_SETUP;
      ST_SETUP: if (r_cnt == CNT_W'(CS_SETUP - 1)) w_next = ST_SHIFT;
      ST_SHIFT: if (w_tick && r_phase && w_last_bit) w_next = ST_HOLD;
      ST_HOLD:  if (r_cnt == CNT_W'(CS_HOLD - 1)) w_next = ST_GAP;
      ST_GAP:   if (w_gap_end) w_next = (r_pend_v || w_req) ? ST_SETUP : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_frame = (r_state == ST_SETUP) || (r_state == ST_SHIFT) || (r_state == ST_HOLD);
    dac_cs_n   = !w_in_frame;
    dac_sclk   = !((r_state == ST_SHIFT) && !r_phase);
    dac_din    = w_in_frame && r_shift[WORD_W-1];
    busy       = (r_state != ST_IDLE);
    done       = (r_state == ST_GAP) && (r_cnt == '0);
    overrun    = r_overrun;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_set_d   <= 1'b0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_phase   <= 1'b0;
      r_bit_cnt <= '0;
      r_pend_v  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_set_d   <= dac_set;
      r_overrun <= w_req && r_pend_v && (r_state != ST_IDLE);

      if ((w_next != r_state) || (r_state == ST_SHIFT) || (r_state == ST_IDLE)) r_cnt <= '0;
      else                                                                      r_cnt <= r_cnt + 1'b1;

      // The DAC samples on the falling edge, so DIN advances on the rising edge that ends the low half.
      if (w_load)                                        r_shift <= w_load_word;
      else if ((r_state == ST_SHIFT) && w_tick && !r_phase) r_shift <= {r_shift[WORD_W-2:0], 1'b0};

      if (r_state != ST_SHIFT) r_phase <= 1'b0;
      else if (w_tick)         r_phase <= !r_phase;

      if (r_state != ST_SHIFT)                      r_bit_cnt <= '0;
      else if (w_tick && r_phase && !w_last_bit)    r_bit_cnt <= r_bit_cnt + 1'b1;

      if (w_gap_end && (r_pend_v || w_req))         r_pend_v <= 1'b0;
      else if (w_req && (r_state != ST_IDLE))       r_pend_v <= 1'b1;
    end
  end

  // NOTE: the pending data word has no reset; r_pend_v alone decides whether it is ever used.
  always_ff @(posedge clk) begin
    if (w_req && (r_state != ST_IDLE) && !w_gap_end) r_pend <= dac_value;
  end

endmodule

// File: tb/tb_dac_serial_if.sv
// Directed bench for dac_serial_if: decodes frames on SCLK falling edges and checks framing timing.
module tb_dac_serial_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dac_value = 16'h0000;
  logic        dac_set = 1'b0;
  logic        dac_cs_n, dac_sclk, dac_din, busy, done, overrun;

  logic [15:0] f_value = 16'h0000;
  logic        f_set = 1'b0;
  logic        f_cs_n, f_sclk, f_din, f_busy, f_done, f_ovr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dac_serial_if u_dut (
    .clk(clk), .rst(rst), .dac_value(dac_value), .dac_set(dac_set),
    .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_din(dac_din),
    .busy(busy), .done(done), .overrun(overrun)
  );

  dac_serial_if #(.CLK_DIV(1)) u_dut_fast (
    .clk(clk), .rst(rst), .dac_value(f_value), .dac_set(f_set),
    .dac_cs_n(f_cs_n), .dac_sclk(f_sclk), .dac_din(f_din),
    .busy(f_busy), .done(f_done), .overrun(f_ovr)
  );

  // Frame monitor, sampling on the falling clk edge.
  int          cyc = 0;
  logic        prev_cs_n = 1'b1, prev_sclk = 1'b1, prev_busy = 1'b0, prev_set = 1'b0;
  logic [15:0] sh = 16'h0000;
  int          bitn = 0, cs_len = 0, busy_len = 0, cs_fall = 0, first_fall = -1;
  int          set_rise = 0, n_cs_fall = 0, done_cnt = 0, ovr_cnt = 0;
  int          words_q[$], cslen_q[$], bits_q[$], csfall_q[$], csrise_q[$], ffall_q[$], busy_q[$];
  int          f_busy_cnt = 0, f_cs_cnt = 0, f_done_cnt = 0;

  always @(negedge clk) begin
    cyc++;
    if (dac_set && !prev_set) set_rise = cyc;
    if (prev_cs_n && !dac_cs_n) begin
      cs_fall = cyc; cs_len = 0; bitn = 0; first_fall = -1; n_cs_fall++;
    end
    if (!dac_cs_n) cs_len++;
    if (prev_sclk && !dac_sclk) begin
      sh = {sh[14:0], dac_din};
      bitn++;
      if (first_fall < 0) first_fall = cyc;
    end
    if (!prev_cs_n && dac_cs_n && rst) begin
      words_q.push_back(int'(sh)); cslen_q.push_back(cs_len); bits_q.push_back(bitn);
      csfall_q.push_back(cs_fall); csrise_q.push_back(cyc); ffall_q.push_back(first_fall);
    end
    if (busy && !prev_busy) busy_len = 0;
    if (busy) busy_len++;
    if (!busy && prev_busy && rst) busy_q.push_back(busy_len);
    if (done) done_cnt++;
    if (overrun) ovr_cnt++;
    if (f_busy) f_busy_cnt++;
    if (!f_cs_n) f_cs_cnt++;
    if (f_done) f_done_cnt++;
    prev_cs_n = dac_cs_n; prev_sclk = dac_sclk; prev_busy = busy; prev_set = dac_set;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic wait_frames(input int n, input string name);
    int k = 0;
    @(negedge clk); #1;
    while ((words_q.size() < n || busy) && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, " timeout"}, int'(k >= 2000), 0);
  endtask

  task automatic wait_bit(input int n, input string name);
    int k = 0;
    while (bitn < n && k < 2000) begin
      @(negedge clk); #1;
      k++;
    end
    check({name, " bit wait timeout"}, int'(k >= 2000), 0);
  endtask

  task automatic pulse(input logic [15:0] v);
    dac_value = v; dac_set = 1'b1;
    tick(1);
    dac_set = 1'b0;
    tick(1);
  endtask

  typedef struct {
    logic [15:0] value;
    int          hold;
    logic [15:0] exp_word;
    int          exp_cs_len;
    int          exp_busy_len;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int b, o;

    vecs[0] = '{16'h89B0, 1, 16'h89B0, 132, 136};
    vecs[1] = '{16'h1230, 5, 16'h1230, 132, 136};
    vecs[2] = '{16'h8001, 1, 16'h8001, 132, 136};
    vecs[3] = '{16'h7FFE, 2, 16'h7FFE, 132, 136};

    // Reset state, with the strobe already high so release counts as a request.
    #1 rst = 1'b0;
    dac_value = 16'h07B0; dac_set = 1'b1;
    @(negedge clk); #1;
    check("reset outputs", int'({dac_cs_n, dac_sclk, dac_din, busy, done, overrun}), 'b110000);
    @(posedge clk); #1 rst = 1'b1;

    wait_frames(1, "t1");
    dac_set = 1'b0;
    check("t1 word", words_q[0], 'h07B0);
    check("t1 bits", bits_q[0], 16);
    check("t1 cs_n low len", cslen_q[0], 132);
    check("t1 busy len", busy_q[0], 136);
    check("t1 done count", done_cnt, 1);
    check("t1 overrun count", ovr_cnt, 0);
    tick(3);

    for (int i = 0; i < 4; i++) begin
      b = words_q.size();
      dac_value = vecs[i].value; dac_set = 1'b1;
      tick(vecs[i].hold);
      dac_set = 1'b0;
      wait_frames(b + 1, $sformatf("vec%0d", i));
      tick(20);
      check($sformatf("vec%0d frame count", i), words_q.size(), b + 1);
      check($sformatf("vec%0d word", i), words_q[b], int'(vecs[i].exp_word));
      check($sformatf("vec%0d cs_n delay", i), csfall_q[b] - set_rise, 1);
      check($sformatf("vec%0d first sclk fall", i), ffall_q[b] - csfall_q[b], 2);
      check($sformatf("vec%0d cs_n low len", i), cslen_q[b], vecs[i].exp_cs_len);
      check($sformatf("vec%0d busy len", i), busy_q[busy_q.size()-1], vecs[i].exp_busy_len);
    end

    // Request mid-frame is buffered and follows straight after the gap.
    b = words_q.size(); o = ovr_cnt;
    pulse(16'h0F0F);
    wait_bit(5, "t3");
    pulse(16'h0850);
    wait_frames(b + 2, "t3");
    check("t3 first word", words_q[b], 'h0F0F);
    check("t3 second word", words_q[b+1], 'h0850);
    check("t3 gap len", csfall_q[b+1] - csrise_q[b], 4);
    check("t3 busy len", busy_q[busy_q.size()-1], 272);
    check("t3 overrun", ovr_cnt - o, 0);
    tick(5);

    // Two mid-frame requests: latest wins, one overrun.
    b = words_q.size(); o = ovr_cnt;
    pulse(16'hA5C3);
    wait_bit(3, "t4");
    pulse(16'h0850);
    pulse(16'h0860);
    wait_frames(b + 2, "t4");
    tick(10);
    check("t4 first word", words_q[b], 'hA5C3);
    check("t4 second word", words_q[b+1], 'h0860);
    check("t4 frame count", words_q.size(), b + 2);
    check("t4 overrun", ovr_cnt - o, 1);

    // CLK_DIV=1 build: whole frame 2 + 32 + 2 + 4 clk.
    f_value = 16'h1230; f_set = 1'b1;
    tick(5);
    f_set = 1'b0;
    tick(60);
    check("fast busy len", f_busy_cnt, 40);
    check("fast cs_n low len", f_cs_cnt, 36);
    check("fast done count", f_done_cnt, 1);

    // Reset mid-frame with a word pending: nothing resumes afterwards.
    b = words_q.size();
    pulse(16'h4321);
    wait_bit(5, "t6");
    pulse(16'h0850);
    wait_bit(7, "t6");
    @(posedge clk); #1;
    check("t6 cs_n low before reset", int'(dac_cs_n), 0);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    check("t6 outputs in reset", int'({dac_cs_n, dac_sclk, dac_din, busy, done, overrun}), 'b110000);
    o = n_cs_fall;
    tick(3);
    rst = 1'b1;
    tick(300);
    check("t6 no frame after reset", n_cs_fall - o, 0);
    check("t6 frame count", words_q.size(), b);
    check("t6 busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
